iterative_mac_unit: RTL and testbench



---
 rtl/iterative_mac_unit.sv | 162 ++++++++++++++++
 tb/tb_iterative_mac_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/iterative_mac_unit.sv
// Iterative shift-add HI/LO multiply-accumulate unit.
// Retires BITS_PER_CYCLE multiplier bits per cycle, then accumulates into HI/LO.
module iterative_mac_unit #(
   parameter int BUS_WIDTH      = 32,
   parameter int BITS_PER_CYCLE = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [3:0]           mul_op,
   input  logic [BUS_WIDTH-1:0] in1,
   input  logic [BUS_WIDTH-1:0] in2,
   output logic                 busy,
   output logic                 done,
   output logic [BUS_WIDTH-1:0] hi,
   output logic [BUS_WIDTH-1:0] lo
);

   localparam int W   = BUS_WIDTH;
   localparam int BPC = BITS_PER_CYCLE;
   localparam int N   = W / BPC;
   localparam int CW  = $clog2(N + 1);

   localparam logic [3:0] OP_MUL   = 4'b0000;
   localparam logic [3:0] OP_MULU  = 4'b0001;
   localparam logic [3:0] OP_MADD  = 4'b0010;
   localparam logic [3:0] OP_MADDU = 4'b0011;
   localparam logic [3:0] OP_MSUB  = 4'b0100;
   localparam logic [3:0] OP_MSUBU = 4'b0101;
   localparam logic [3:0] OP_MTHI  = 4'b0110;
   localparam logic [3:0] OP_MTLO  = 4'b0111;

   generate
      if (BUS_WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_bpc
         $error("BITS_PER_CYCLE must divide BUS_WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_MULT,
      S_ACC
   } state_t;

   state_t           state_q, state_d;
   logic [3:0]       op_q, op_d;
   logic             neg_q, neg_d;
   logic [2*W-1:0]   mcand_q, mcand_d;
   logic [W-1:0]     mplier_q, mplier_d;
   logic [2*W-1:0]   prod_q, prod_d;
   logic [2*W-1:0]   base_q, base_d;
   logic [CW-1:0]    count_q, count_d;
   logic [W-1:0]     hi_q, hi_d;
   logic [W-1:0]     lo_q, lo_d;
   logic             done_q, done_d;

   logic             is_mul, is_sgn;
   logic [W:0]       ext1, ext2, mag1, mag2;
   logic [2*W-1:0]   partial, p, res;

   assign is_mul = (mul_op == OP_MUL)  || (mul_op == OP_MULU)  ||
                   (mul_op == OP_MADD) || (mul_op == OP_MADDU) ||
                   (mul_op == OP_MSUB) || (mul_op == OP_MSUBU);
   assign is_sgn = ~mul_op[0];

   // W+1 bits so the most-negative operand keeps its 2^(W-1) magnitude
   assign ext1 = {is_sgn & in1[W-1], in1};
   assign ext2 = {is_sgn & in2[W-1], in2};
   assign mag1 = ext1[W] ? -ext1 : ext1;
   assign mag2 = ext2[W] ? -ext2 : ext2;

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      neg_d    = neg_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prod_d   = prod_q;
      base_d   = base_q;
      count_d  = count_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      partial  = '0;
      p        = '0;
      res      = '0;
      case (state_q)
         S_IDLE: begin
            if (start && is_mul) begin
               op_d     = mul_op;
               neg_d    = is_sgn & (in1[W-1] ^ in2[W-1]);
               mcand_d  = {{(W-1){1'b0}}, mag1};
               mplier_d = mag2[W-1:0];
               prod_d   = '0;
               base_d   = {hi_q, lo_q};
               count_d  = '0;
               state_d  = S_MULT;
            end else if (start && mul_op == OP_MTHI) begin
               hi_d = in1;
            end else if (start && mul_op == OP_MTLO) begin
               lo_d = in1;
            end
         end
         S_MULT: begin
            for (int b = 0; b < BPC; b++) begin
               if (mplier_q[b]) partial = partial + (mcand_q << b);
            end
            prod_d   = prod_q + partial;
            mcand_d  = mcand_q << BPC;
            mplier_d = mplier_q >> BPC;
            count_d  = count_q + 1'b1;
            if (count_q == CW'(N - 1)) state_d = S_ACC;
         end
         S_ACC: begin
            p = neg_q ? -prod_q : prod_q;
            case (op_q)
               OP_MADD, OP_MADDU: res = base_q + p;
               OP_MSUB, OP_MSUBU: res = base_q - p;
               default:           res = p;
            endcase
            {hi_d, lo_d} = res;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         neg_q    <= 1'b0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prod_q   <= '0;
         base_q   <= '0;
         count_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prod_q   <= prod_d;
         base_q   <= base_d;
         count_q  <= count_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
      end
   end

   assign busy = (state_q != S_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_iterative_mac_unit.sv
// Scoreboard bench for iterative_mac_unit (W=32, BPC=2, N=16).
// Expected HI/LO and completion edge are queued at issue; a monitor checks on done.
module tb_iterative_mac_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  mul_op;
   logic [31:0] in1, in2;
   logic        busy, done;
   logic [31:0] hi, lo;

   iterative_mac_unit #(.BUS_WIDTH(32), .BITS_PER_CYCLE(2)) dut (
      .clk(clk), .rst(rst), .start(start), .mul_op(mul_op),
      .in1(in1), .in2(in2), .busy(busy), .done(done),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] v;
      int          edge_n;
      string       name;
   } exp_t;

   exp_t q[$];
   int n_checks = 0;
   int n_fails  = 0;
   int n_done   = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fails++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // start accepted at the next edge (cyc+1); done visible 17 edges later
   task automatic issue(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit push,
                        input logic [63:0] expv, input string name);
      exp_t e;
      @(negedge clk);
      start = 1'b1; mul_op = op; in1 = a; in2 = b;
      if (push) begin
         e.v = expv; e.edge_n = cyc + 18; e.name = name;
         q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 60 && (busy || q.size() != 0); i++)
         @(negedge clk);
      chk({name, "_drain"}, 64'(q.size()), 64'd0);
      chk({name, "_busy"}, {63'd0, busy}, 64'd0);
   endtask

   task automatic mtx(input logic [3:0] op, input logic [31:0] v);
      issue(op, v, 32'd0, 1'b0, 64'd0, "mt");
   endtask

   initial begin
      int d0;
      exp_t e;
      rst = 1'b1; start = 1'b0; mul_op = 4'd0; in1 = '0; in2 = '0;
      fork
         forever begin
            @(negedge clk);
            if (done === 1'b1) begin
               n_done++;
               chk("done_expected", {63'd0, q.size() != 0}, 64'd1);
               if (q.size() != 0) begin
                  e = q.pop_front();
                  chk(e.name, {hi, lo}, e.v);
                  chk({e.name, "_edge"}, 64'(cyc), 64'(e.edge_n));
                  chk({e.name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
               end
            end
         end
      join_none

      repeat (2) @(negedge clk);
      chk("reset_hilo", {hi, lo}, 64'd0);
      chk("reset_busy_done", {62'd0, busy, done}, 64'd0);
      rst = 1'b0;

      issue(4'b0000, 32'hFFFFFFFD, 32'd5, 1'b1,
            64'hFFFFFFFF_FFFFFFF1, "mul_m3x5");
      chk("busy_in_flight", {63'd0, busy}, 64'd1);
      wait_idle("mul_m3x5");

      issue(4'b0000, 32'd5, 32'hFFFFFFF9, 1'b1,
            64'hFFFFFFFF_FFFFFFDD, "mul_5xm7");
      wait_idle("mul_5xm7");

      mtx(4'b0110, 32'd0);
      mtx(4'b0111, 32'hFFFFFFFF);
      chk("mthi_mtlo", {hi, lo}, 64'h00000000_FFFFFFFF);
      chk("mt_no_busy", {62'd0, busy, done}, 64'd0);
      issue(4'b0011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
            64'hFFFFFFFF_00000000, "maddu_max");
      wait_idle("maddu_max");

      mtx(4'b0110, 32'd0);
      mtx(4'b0111, 32'd0);
      issue(4'b0100, 32'd2, 32'd3, 1'b1,
            64'hFFFFFFFF_FFFFFFFA, "msub_2x3");
      wait_idle("msub_2x3");
      mtx(4'b0110, 32'd0);
      mtx(4'b0111, 32'd0);
      issue(4'b0101, 32'd2, 32'd3, 1'b1,
            64'hFFFFFFFF_FFFFFFFA, "msubu_2x3");
      wait_idle("msubu_2x3");

      issue(4'b0000, 32'h80000000, 32'h80000000, 1'b1,
            64'h40000000_00000000, "mul_minneg");
      wait_idle("mul_minneg");
      issue(4'b0001, 32'h80000000, 32'h80000000, 1'b1,
            64'h40000000_00000000, "mulu_minneg");
      wait_idle("mulu_minneg");

      issue(4'b1111, 32'd9, 32'd9, 1'b0, 64'd0, "nop");
      chk("nop_ignored", {hi, lo}, 64'h40000000_00000000);
      chk("nop_no_busy", {63'd0, busy}, 64'd0);

      d0 = n_done;
      issue(4'b0000, 32'd7, 32'd9, 1'b1, 64'h00000000_0000003F, "mul_7x9");
      repeat (4) @(negedge clk);
      start = 1'b1; mul_op = 4'b0110; in1 = 32'h1234; in2 = 32'd0;
      @(negedge clk);
      mul_op = 4'b0000; in1 = 32'd2; in2 = 32'd2;
      @(negedge clk);
      start = 1'b0;
      chk("hilo_stable_mult", {hi, lo}, 64'h40000000_00000000);
      wait_idle("mul_7x9");
      chk("busy_start_ignored", {hi, lo}, 64'h00000000_0000003F);
      chk("one_done", 64'(n_done - d0), 64'd1);

      d0 = n_done;
      issue(4'b0000, 32'd7, 32'd9, 1'b0, 64'd0, "mul_rst");
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midop_reset_hilo", {hi, lo}, 64'd0);
      chk("midop_reset_busy", {62'd0, busy, done}, 64'd0);
      repeat (20) @(negedge clk);
      chk("no_done_after_rst", 64'(n_done - d0), 64'd0);
      issue(4'b0000, 32'd2, 32'd3, 1'b1, 64'h00000000_00000006, "mul_2x3");
      wait_idle("mul_2x3");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fails);
      $finish;
   end

endmodule
